// File: rtl/axi_wb_pkg.sv
// Shared types and constants for the Wishbone-to-AXI-Lite bridge.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_wb_pkg;

    // Bridge FSM states: request phase, response phase, one-cycle completion.
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } bridge_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // OKAY and EXOKAY both complete as a Wishbone ack; the rest become err.
    function automatic logic resp_is_ok(input logic [1:0] resp);
        logic ok;
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   ok = 1'b1;
            RESP_SLVERR, RESP_DECERR: ok = 1'b0;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wishbone_to_axi_lite_if.sv
// Bundles the Wishbone slave port and the AXI-Lite master port of the bridge.
// Latency: none (wires only).
// Backpressure: AXI ready/valid pairs; Wishbone classic stb held until ack/err.
interface wishbone_to_axi_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Wishbone side
    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdata;
    logic [DW/8-1:0] s_sel;
    logic [DW-1:0] s_rdata;
    logic          s_ack;
    logic          s_err;

    // AXI-Lite side
    logic          m_awvalid;
    logic [AW-1:0] m_awaddr;
    logic          m_awready;
    logic          m_wvalid;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic          m_wready;
    logic          m_bvalid;
    logic [1:0]    m_bresp;
    logic          m_bready;
    logic          m_arvalid;
    logic [AW-1:0] m_araddr;
    logic          m_arready;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rready;

    // Bridge view: Wishbone slave toward the CPU bus, AXI master toward peripherals.
    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_wdata, s_sel,
        output s_rdata, s_ack, s_err,
        output m_awvalid, m_awaddr, input m_awready,
        output m_wvalid, m_wdata, m_wstrb, input m_wready,
        input  m_bvalid, m_bresp, output m_bready,
        output m_arvalid, m_araddr, input m_arready,
        input  m_rvalid, m_rdata, m_rresp, output m_rready
    );

    // Environment view: Wishbone master plus AXI-Lite peripheral.
    modport master (
        output s_cyc, s_stb, s_we, s_adr, s_wdata, s_sel,
        input  s_rdata, s_ack, s_err,
        input  m_awvalid, m_awaddr, output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, output m_wready,
        output m_bvalid, m_bresp, input m_bready,
        input  m_arvalid, m_araddr, output m_arready,
        output m_rvalid, m_rdata, m_rresp, input m_rready
    );

endinterface

// File: rtl/wishbone_to_axi_lite.sv
// Wishbone B4 classic slave to AXI4-Lite master bridge, one transaction in flight.
// Latency: 3 cycles stb-sampled to ack with a zero-wait AXI slave; 4-cycle minimum issue interval.
// Backpressure: holds each AXI valid until its ready; Wishbone is stalled by withholding ack/err.
module wishbone_to_axi_lite
    import axi_wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic clk,
    input  logic rst,
    wishbone_to_axi_lite_if.slave bus
);

    bridge_state_t   state, state_n;

    // Request register: one copy serves both AW and AR address outputs.
    logic [AW-1:0]   adr_q,   adr_n;
    logic [DW-1:0]   wdata_q, wdata_n;
    logic [DW/8-1:0] sel_q,   sel_n;

    logic awvalid_q, awvalid_n;
    logic wvalid_q,  wvalid_n;
    logic arvalid_q, arvalid_n;
    logic bready_q,  bready_n;
    logic rready_q,  rready_n;
    logic aw_done_q, aw_done_n;
    logic w_done_q,  w_done_n;

    // Set once the master drops s_cyc mid-transaction; silences the completion.
    logic aborted_q, aborted_n;

    logic [DW-1:0] rdata_q, rdata_n;
    logic          ack_q,   ack_n;
    logic          err_q,   err_n;

    // Next-state and next-register values for the bridge FSM.
    always_comb begin
        state_n   = state;
        adr_n     = adr_q;
        wdata_n   = wdata_q;
        sel_n     = sel_q;
        awvalid_n = awvalid_q;
        wvalid_n  = wvalid_q;
        arvalid_n = arvalid_q;
        bready_n  = bready_q;
        rready_n  = rready_q;
        aw_done_n = aw_done_q;
        w_done_n  = w_done_q;
        aborted_n = aborted_q;
        rdata_n   = rdata_q;
        ack_n     = 1'b0;
        err_n     = 1'b0;

        // Any cycle outside IDLE/DONE with s_cyc low marks the transaction abandoned.
        if (state != IDLE && state != DONE && !bus.s_cyc) begin
            aborted_n = 1'b1;
        end

        case (state)
            IDLE: begin
                aborted_n = 1'b0;
                if (bus.s_cyc && bus.s_stb) begin
                    adr_n     = bus.s_adr;
                    wdata_n   = bus.s_wdata;
                    sel_n     = bus.s_sel;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    if (bus.s_we) begin
                        state_n   = WR_REQ;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_REQ;
                        arvalid_n = 1'b1;
                    end
                end
            end

            WR_REQ: begin
                // AW and W retire independently; B is only opened after both.
                if (awvalid_q && bus.m_awready) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (wvalid_q && bus.m_wready) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if (aw_done_n && w_done_n) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end

            WR_RESP: begin
                if (bus.m_bvalid) begin
                    bready_n = 1'b0;
                    state_n  = DONE;
                    ack_n    = !aborted_n &&  resp_is_ok(bus.m_bresp);
                    err_n    = !aborted_n && !resp_is_ok(bus.m_bresp);
                end
            end

            RD_REQ: begin
                if (bus.m_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_RESP;
                end
            end

            RD_RESP: begin
                if (bus.m_rvalid) begin
                    rdata_n  = bus.m_rdata;
                    rready_n = 1'b0;
                    state_n  = DONE;
                    ack_n    = !aborted_n &&  resp_is_ok(bus.m_rresp);
                    err_n    = !aborted_n && !resp_is_ok(bus.m_rresp);
                end
            end

            DONE: begin
                // ack/err were raised on entry; s_stb is ignored here.
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request, handshake and response registers; every output comes from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q     <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aborted_q <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            adr_q     <= adr_n;
            wdata_q   <= wdata_n;
            sel_q     <= sel_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            arvalid_q <= arvalid_n;
            bready_q  <= bready_n;
            rready_q  <= rready_n;
            aw_done_q <= aw_done_n;
            w_done_q  <= w_done_n;
            aborted_q <= aborted_n;
            rdata_q   <= rdata_n;
            ack_q     <= ack_n;
            err_q     <= err_n;
        end
    end

    assign bus.m_awvalid = awvalid_q;
    assign bus.m_awaddr  = adr_q;
    assign bus.m_wvalid  = wvalid_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = sel_q;
    assign bus.m_bready  = bready_q;
    assign bus.m_arvalid = arvalid_q;
    assign bus.m_araddr  = adr_q;
    assign bus.m_rready  = rready_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_ack     = ack_q;
    assign bus.s_err     = err_q;

endmodule
